// File: rtl/ps2_key_decoder.sv
// PS/2 scan-set-2 receiver and pressed-key bitmap indexed by {ext, code}.
// Optional odd-parity rejection is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ps2_clk,
    input  logic         ps2_data,
    output logic [511:0] key_down,
    output logic [8:0]   last_change,
    output logic         key_valid,
    output logic         frame_err
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    logic [1:0]       clk_sync;
    logic [1:0]       data_sync;
    logic             clk_d;
    logic             fall_p0;
    logic             bit_p0;
    logic [3:0]       bit_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [7:0]       shift_p1;
    logic             byte_vld_p1;
    logic             parity_ok;
    state_t           state;
    state_t           next_state;
    logic             upd;
    logic [8:0]       upd_code;
    logic             upd_val;

`ifdef PS2_PARITY_CHECK_EN
    logic parity_p1;
    assign parity_ok = ^{shift_p1, parity_p1};
`else
    assign parity_ok = 1'b1;
`endif

    // Stage p0: pin synchronisers and registered falling-edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_d     <= 1'b1;
            fall_p0   <= 1'b0;
            bit_p0    <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_d     <= clk_sync[1];
            fall_p0   <= clk_d & ~clk_sync[1];
            bit_p0    <= data_sync[1];
        end
    end

    // Stage p1: frame deserialiser with idle timeout; a sampled edge beats an expiring timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt     <= 4'd0;
            tmo_cnt     <= '0;
            shift_p1    <= 8'h00;
            byte_vld_p1 <= 1'b0;
            frame_err   <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_p1   <= 1'b0;
`endif
        end else begin
            byte_vld_p1 <= 1'b0;
            frame_err   <= 1'b0;
            if (fall_p0) begin
                tmo_cnt <= '0;
                if (bit_cnt == 4'd0) begin
                    if (!bit_p0) bit_cnt <= 4'd1;
                end else if (bit_cnt <= 4'd8) begin
                    shift_p1 <= {bit_p0, shift_p1[7:1]};
                    bit_cnt  <= bit_cnt + 4'd1;
                end else if (bit_cnt == 4'd9) begin
`ifdef PS2_PARITY_CHECK_EN
                    parity_p1 <= bit_p0;
`endif
                    bit_cnt <= 4'd10;
                end else begin
                    bit_cnt <= 4'd0;
                    if (!bit_p0)
                        frame_err <= 1'b1;
                    else if (!parity_ok)
                        frame_err <= 1'b1;
                    else
                        byte_vld_p1 <= 1'b1;
                end
            end else if (bit_cnt != 4'd0) begin
                if (tmo_cnt == TMO_LAST) begin
                    bit_cnt   <= 4'd0;
                    tmo_cnt   <= '0;
                    frame_err <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        upd        = 1'b0;
        upd_code   = {(state == EXT) || (state == EXT_BRK), shift_p1};
        upd_val    = !((state == BRK) || (state == EXT_BRK));
        if (byte_vld_p1) begin
            case (shift_p1)
                8'hE0: next_state = EXT;
                8'hF0: begin
                    if (state == IDLE)     next_state = BRK;
                    else if (state == EXT) next_state = EXT_BRK;
                end
                // Keyboard status/ack bytes carry no key information
                8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: ;
                default: begin
                    upd        = 1'b1;
                    next_state = IDLE;
                end
            endcase
        end
    end

    // Stage p2: registered bitmap and change report
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_down    <= '0;
            last_change <= 9'h000;
            key_valid   <= 1'b0;
        end else begin
            key_valid <= upd;
            if (upd) begin
                key_down[upd_code] <= upd_val;
                last_change        <= upd_code;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: frames driven on the PS/2 pins, results checked by immediate assertions.
module tb_ps2_key_decoder;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ps2_clk = 1'b1;
    logic         ps2_data = 1'b1;
    logic [511:0] key_down;
    logic [8:0]   last_change;
    logic         key_valid;
    logic         frame_err;

    ps2_key_decoder #(.TIMEOUT_CYCLES(1000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .key_down    (key_down),
        .last_change (last_change),
        .key_valid   (key_valid),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int kv_cnt = 0, fe_cnt = 0, ovl_cnt = 0, last_kv_cyc = 0, last_fall_cyc = 0;
    int checks = 0, passed = 0;
    int kv0, fe0;

    // High cycles are counted, so a stretched pulse shows up as an extra count
    always @(negedge clk) begin
        if (key_valid) begin
            kv_cnt++;
            last_kv_cyc = cyc;
        end
        if (frame_err) fe_cnt++;
        if (key_valid && frame_err) ovl_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        repeat (8) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par = 1'b0,
                              input logic stop = 1'b1, input int nbits = 11);
        logic [10:0] f;
        f = {stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(f[i]);
        repeat (10) @(negedge clk);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        chk("rst_key_valid", {31'b0, key_valid}, 32'd0);
        chk("rst_frame_err", {31'b0, frame_err}, 32'd0);
        chk("rst_last_change", {23'b0, last_change}, 32'd0);
        chk("rst_key_down", {31'b0, key_down == '0}, 32'd1);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // make / break of F
        kv0 = kv_cnt;
        send_frame(8'h2B);
        chk("make_2b_bit", {31'b0, key_down[9'h02B]}, 32'd1);
        chk("make_2b_last", {23'b0, last_change}, 32'h02B);
        chk("make_2b_pulses", kv_cnt - kv0, 32'd1);
        chk("pin_to_valid", last_kv_cyc - last_fall_cyc, 32'd5);
        send_frame(8'hF0);
        chk("f0_no_pulse", kv_cnt - kv0, 32'd1);
        chk("f0_bit_held", {31'b0, key_down[9'h02B]}, 32'd1);
        send_frame(8'h2B);
        chk("break_2b_bit", {31'b0, key_down[9'h02B]}, 32'd0);
        chk("break_2b_pulses", kv_cnt - kv0, 32'd2);
        chk("break_2b_last", {23'b0, last_change}, 32'h02B);

        // extended key
        kv0 = kv_cnt;
        send_frame(8'hE0);
        send_frame(8'h75);
        chk("ext_make_bit", {31'b0, key_down[9'h175]}, 32'd1);
        chk("ext_make_last", {23'b0, last_change}, 32'h175);
        chk("ext_make_plain", {31'b0, key_down[9'h075]}, 32'd0);
        send_frame(8'hE0);
        send_frame(8'hF0);
        send_frame(8'h75);
        chk("ext_break_bit", {31'b0, key_down[9'h175]}, 32'd0);
        chk("ext_break_plain", {31'b0, key_down[9'h075]}, 32'd0);
        chk("ext_break_last", {23'b0, last_change}, 32'h175);
        chk("ext_pulses", kv_cnt - kv0, 32'd2);

        // overlapping keys, status byte ignored
        kv0 = kv_cnt;
        send_frame(8'h2B);
        send_frame(8'h34);
        send_frame(8'hFA);
        send_frame(8'h33);
        send_frame(8'h3B);
        send_frame(8'hF0);
        send_frame(8'h34);
        chk("ovl_2b", {31'b0, key_down[9'h02B]}, 32'd1);
        chk("ovl_33", {31'b0, key_down[9'h033]}, 32'd1);
        chk("ovl_3b", {31'b0, key_down[9'h03B]}, 32'd1);
        chk("ovl_34", {31'b0, key_down[9'h034]}, 32'd0);
        chk("ovl_pulses", kv_cnt - kv0, 32'd5);
        send_frame(8'hF0);
        send_frame(8'h2B);
        chk("ovl_clear_2b", {31'b0, key_down[9'h02B]}, 32'd0);

        // bad parity on 2B
        kv0 = kv_cnt;
        fe0 = fe_cnt;
        send_frame(8'h2B, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        chk("par_err", fe_cnt - fe0, 32'd1);
        chk("par_bit", {31'b0, key_down[9'h02B]}, 32'd0);
        chk("par_pulses", kv_cnt - kv0, 32'd0);
`else
        chk("par_err", fe_cnt - fe0, 32'd0);
        chk("par_bit", {31'b0, key_down[9'h02B]}, 32'd1);
        chk("par_pulses", kv_cnt - kv0, 32'd1);
`endif
        send_frame(8'hF0);
        send_frame(8'h2B);

        // stop bit error
        kv0 = kv_cnt;
        fe0 = fe_cnt;
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("stop_err", fe_cnt - fe0, 32'd1);
        chk("stop_pulses", kv_cnt - kv0, 32'd0);
        chk("stop_bit", {31'b0, key_down[9'h01C]}, 32'd0);

        // timeout after 6 bits, then recovery
        fe0 = fe_cnt;
        kv0 = kv_cnt;
        send_frame(8'h1C, 1'b0, 1'b1, 6);
        repeat (1100) @(negedge clk);
        chk("tmo_err", fe_cnt - fe0, 32'd1);
        send_frame(8'h1C);
        chk("tmo_recover_bit", {31'b0, key_down[9'h01C]}, 32'd1);
        chk("tmo_recover_err", fe_cnt - fe0, 32'd1);
        chk("tmo_recover_pulses", kv_cnt - kv0, 32'd1);

        // reset mid-prefix and mid-frame
        send_frame(8'hE0);
        send_frame(8'h2B, 1'b0, 1'b1, 4);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rst_key_down", {31'b0, key_down == '0}, 32'd1);
        chk("mid_rst_last", {23'b0, last_change}, 32'd0);
        chk("mid_rst_valid", {31'b0, key_valid}, 32'd0);
        chk("mid_rst_err", {31'b0, frame_err}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h2B);
        chk("post_rst_02b", {31'b0, key_down[9'h02B]}, 32'd1);
        chk("post_rst_12b", {31'b0, key_down[9'h12B]}, 32'd0);
        chk("post_rst_last", {23'b0, last_change}, 32'h02B);

        chk("no_overlap", ovl_cnt, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receives the raw PS/2 keyboard line (ps2_clk, ps2_data), deframes scan-set-2 bytes, and keeps a 512-entry pressed-key bitmap. Make, break (F0) and extended (E0) codes are interpreted, so each bit reflects whether that key is currently held. This block is the stage directly upstream of the game's per-key press detectors, which index `key_down` by 9-bit code, e.g. `key_down[9'h02B]` for F.

## Interface
- `TIMEOUT_CYCLES`, default 100000: idle `clk` cycles inside a partial frame before that frame is abandoned (1 ms at 100 MHz).
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock from the pin, asynchronous to `clk`.
- `ps2_data`  in  1  raw PS/2 data from the pin, asynchronous to `clk`.
- `key_down`  out  512  bit {ext, code} is 1 while that key is held.
- `last_change`  out  9  {ext, code} of the most recent make or break.
- `key_valid`  out  1  one-cycle pulse when `key_down` / `last_change` update.
- `frame_err`  out  1  one-cycle pulse when a frame is rejected.

## Operation
- **Input synchronisation**
  - `ps2_clk` and `ps2_data` each pass through a 2-FF synchroniser.
  - A falling edge is detected when synchronised `ps2_clk` goes 1→0 against a 3rd register.
  - Data is sampled on that edge.
- **Frame receiver**
  - Frame format: 11 bits, LSB first: start (0), d0..d7, odd parity, stop (1).
  - Bit counter runs 0..10.
  - Start-bit position sampled as 1: ignored, counter stays 0, no error.
  - After bit 10:
    - stop = 0 → `frame_err` pulse, byte discarded.
    - Otherwise the byte is handed to the decoder (parity handling: see Configuration).
  - Counter returns to 0 in either case.
- **Timeout**
  - Counter is 17 bits wide (ceil(log2(TIMEOUT_CYCLES + 1))).
  - Clears on every falling edge; counts only while bit counter ≠ 0.
  - Reaching TIMEOUT_CYCLES: bit counter → 0 and `frame_err` pulses.
- **Decoder FSM**
  - States: IDLE, EXT, BRK, EXT_BRK.
  - Byte E0: IDLE→EXT; in any other state → EXT.
  - Byte F0: IDLE→BRK, EXT→EXT_BRK; BRK / EXT_BRK unchanged.
  - Bytes 00, AA, EE, FA, FE, FF: discarded, state unchanged, no pulse.
  - Any other byte b:
    - code = {ext, b}, where ext = 1 in EXT / EXT_BRK.
    - `key_down[code]` = 0 in BRK / EXT_BRK, else 1.
    - `last_change` = code; `key_valid` pulses; state → IDLE.
  - A repeated make for a key already held still pulses `key_valid`; the bit stays 1.
  - A break for a key not held pulses `key_valid`; the bit stays 0.
- **Reset** (at any time, including mid-frame or mid-prefix): all of the following cleared.
  - Synchronisers and edge register reset to 1.
  - Bit counter, timeout counter and shift register to 0.
  - FSM → IDLE.
  - `key_down` = 0, `last_change` = 0, `key_valid` = 0, `frame_err` = 0.

## Timing
- **Latency:** the falling edge that samples the stop bit is registered as a detected edge in cycle N. The decoder sees the byte in N+1. `key_down`, `last_change` and `key_valid` are registered outputs, valid in N+2.
- **Pin-to-output:** 5 `clk` cycles from the `ps2_clk` pin falling edge to `key_valid` high.
- **Pulse width:** `key_valid` and `frame_err` are high for exactly one cycle each.
- **No overlap:** both cannot occur in the same cycle, because one frame yields at most one outcome.
- **Throughput:** one byte per frame. Bytes arrive at most every ~550 µs, so there is no backpressure and no buffering.
- **Timeout tie-break:** a timeout expiring in the same cycle as a falling edge is ignored; the edge wins and the timeout counter clears.

## Configuration
- `PS2_PARITY_CHECK_EN` defined:
  - Odd parity over d0..d7 plus the parity bit is checked.
  - Mismatch → `frame_err` pulse, byte discarded, FSM unchanged.
- `PS2_PARITY_CHECK_EN` undefined:
  - The parity bit is sampled and ignored.
  - Only the stop bit and timeout generate `frame_err`.

## Test plan
- **Make/break F:** frames 2B, then F0 2B.
  - After 2B: `key_down[0x02B]` = 1, `last_change` = 0x02B, one `key_valid`.
  - After F0 2B: bit returns to 0 with a second `key_valid`.
  - F0 alone produces no pulse.
- **Extended key:** E0 75, then E0 F0 75 → `key_down[0x175]` set then cleared; `last_change` = 0x175; `key_down[0x075]` is never touched.
- **Overlap:** 2B, 34, 33, 3B, then F0 34 → bits 0x02B, 0x033, 0x03B remain 1 and 0x034 = 0; four make pulses plus one break pulse.
- **Bad parity on 2B:**
  - With `PS2_PARITY_CHECK_EN` defined: `frame_err` pulses, `key_down` unchanged, no `key_valid`.
  - With it undefined: bit 0x02B sets.
- **Stop-bit error and timeout:**
  - Stop = 0 → `frame_err`, no update.
  - 6 bits then silence for 100000 cycles → `frame_err`; the next full frame 1C sets `key_down[0x01C]`.
- **Reset mid-operation:** after E0 and 4 bits of the next frame, pulse `rst_n` low.
  - All outputs are 0.
  - A following clean frame 2B sets bit 0x02B, not 0x12B.
